// File: rtl/ct_ifu_spsram_ctrl_1024x64_if.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_spsram_ctrl_1024x64_if
// Purpose  : Request/response and SRAM pin bundle for the IFU SPSRAM controller.
// Revision : 1.0 - initial release
// ============================================================================
interface ct_ifu_spsram_ctrl_1024x64_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64
);
   logic                  inv_req;
   logic                  inv_busy;
   logic                  inv_done;
   logic                  wr_vld;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] wr_mask;
   logic                  wr_rdy;
   logic                  rd_vld;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_rdy;
   logic                  rd_data_vld;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [DATA_WIDTH-1:0] sram_q;

   // master = IFU plus SRAM macro side, slave = the controller
   modport master (
      output inv_req, wr_vld, wr_addr, wr_data, wr_mask, rd_vld, rd_addr, sram_q,
      input  inv_busy, inv_done, wr_rdy, rd_rdy, rd_data_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );

   modport slave (
      input  inv_req, wr_vld, wr_addr, wr_data, wr_mask, rd_vld, rd_addr, sram_q,
      output inv_busy, inv_done, wr_rdy, rd_rdy, rd_data_vld, rd_data,
             sram_a, sram_cen, sram_gwen, sram_d, sram_wen
   );
endinterface
`default_nettype wire

// File: rtl/ct_ifu_spsram_ctrl_1024x64.sv
`default_nettype none
// ============================================================================
// Module   : ct_ifu_spsram_ctrl_1024x64
// Purpose  : Arbitrates invalidate-all, fill write and lookup read onto the IFU
//            1024x64 single-port SRAM. Macro CT_SPSRAM_CTRL_RD_FLOP_EN adds a
//            read-data output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module ct_ifu_spsram_ctrl_1024x64 #(
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = 64,
   parameter int INIT_ON_RESET = 1
) (
   input  wire logic                   forever_cpuclk,
   input  wire logic                   cpurst,
   ct_ifu_spsram_ctrl_1024x64_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
   localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INV  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic                  r_init_pend;
   logic                  r_inv_busy;
   logic                  r_inv_done;
   logic                  r_cen;
   logic                  r_gwen;
   logic [ADDR_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_d;
   logic [DATA_WIDTH-1:0] r_wen;
   logic                  r_rd_s1;
   logic                  r_rd_s2;

   logic w_idle;
   logic w_inv_start;
   logic w_wr_go;
   logic w_rd_go;

   // A pending post-reset walk behaves exactly like an inv_req and blocks both ports
   assign w_idle      = (r_state == ST_IDLE);
   assign w_inv_start = w_idle & (bus.inv_req | r_init_pend);
   assign bus.wr_rdy  = w_idle & ~w_inv_start;
   assign bus.rd_rdy  = w_idle & ~w_inv_start & ~bus.wr_vld;
   assign w_wr_go     = bus.wr_vld & bus.wr_rdy;
   assign w_rd_go     = bus.rd_vld & bus.rd_rdy;

   assign bus.inv_busy  = r_inv_busy;
   assign bus.inv_done  = r_inv_done;
   assign bus.sram_a    = r_a;
   assign bus.sram_cen  = r_cen;
   assign bus.sram_gwen = r_gwen;
   assign bus.sram_d    = r_d;
   assign bus.sram_wen  = r_wen;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_init_pend <= (INIT_ON_RESET != 0);
         r_inv_busy  <= 1'b0;
         r_inv_done  <= 1'b0;
         r_cen       <= 1'b1;
         r_gwen      <= 1'b1;
         r_wen       <= '1;
         r_a         <= '0;
         r_d         <= '0;
      end else begin
         r_inv_done <= 1'b0;
         r_cen      <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_inv_start) begin
                  r_state     <= ST_INV;
                  r_init_pend <= 1'b0;
                  r_inv_busy  <= 1'b1;
                  r_cnt       <= '0;
                  r_cen       <= 1'b0;
                  r_gwen      <= 1'b0;
                  r_wen       <= '0;
                  r_d         <= '0;
                  r_a         <= '0;
               end else if (w_wr_go) begin
                  r_cen  <= 1'b0;
                  r_gwen <= 1'b0;
                  r_wen  <= ~bus.wr_mask;
                  r_d    <= bus.wr_data;
                  r_a    <= bus.wr_addr;
               end else if (w_rd_go) begin
                  r_cen  <= 1'b0;
                  r_gwen <= 1'b1;
                  r_wen  <= '1;
                  r_a    <= bus.rd_addr;
               end
            end
            ST_INV: begin
               // Pins already show r_cnt this cycle; stage the next entry or finish
               if (r_cnt == c_last_addr) begin
                  r_state    <= ST_DONE;
                  r_inv_done <= 1'b1;
               end else begin
                  r_cnt  <= r_cnt + c_addr_one;
                  r_cen  <= 1'b0;
                  r_gwen <= 1'b0;
                  r_wen  <= '0;
                  r_d    <= '0;
                  r_a    <= r_cnt + c_addr_one;
               end
            end
            ST_DONE: begin
               r_state    <= ST_IDLE;
               r_inv_busy <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // s1: SRAM read access cycle, s2: Q valid from the macro
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_rd_s1 <= 1'b0;
         r_rd_s2 <= 1'b0;
      end else begin
         r_rd_s1 <= w_rd_go;
         r_rd_s2 <= r_rd_s1;
      end
   end

`ifdef CT_SPSRAM_CTRL_RD_FLOP_EN
   logic                  r_rd_vld_q;
   logic [DATA_WIDTH-1:0] r_rd_data_q;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_rd_vld_q  <= 1'b0;
         r_rd_data_q <= '0;
      end else begin
         r_rd_vld_q <= r_rd_s2;
         if (r_rd_s2) begin
            r_rd_data_q <= bus.sram_q;
         end
      end
   end

   assign bus.rd_data_vld = r_rd_vld_q;
   assign bus.rd_data     = r_rd_data_q;
`else
   logic [DATA_WIDTH-1:0] r_rd_hold;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         r_rd_hold <= '0;
      end else if (r_rd_s2) begin
         r_rd_hold <= bus.sram_q;
      end
   end

   // Q passes straight through in its valid cycle and is held afterwards
   assign bus.rd_data_vld = r_rd_s2;
   assign bus.rd_data     = r_rd_s2 ? bus.sram_q : r_rd_hold;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ct_ifu_spsram_ctrl_1024x64.sv
`default_nettype none
// ============================================================================
// Module   : tb_ct_ifu_spsram_ctrl_1024x64
// Purpose  : Self-checking bench with SRAM macro model and read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ct_ifu_spsram_ctrl_1024x64;

`ifdef CT_SPSRAM_CTRL_RD_FLOP_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam logic [63:0] AO = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ct_ifu_spsram_ctrl_1024x64_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) bus ();

   ct_ifu_spsram_ctrl_1024x64 #(
      .ADDR_WIDTH(10), .DATA_WIDTH(64), .INIT_ON_RESET(1)
   ) dut (
      .forever_cpuclk(clk),
      .cpurst(rst),
      .bus(bus)
   );

   // Synchronous SRAM macro: active-low enables, Q registered one cycle after access
   logic [63:0] sram_mem [1024];
   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen)
            sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else
            bus.sram_q <= sram_mem[bus.sram_a];
      end
   end

   typedef struct {
      logic [63:0] data;
      int          cyc;
   } exp_t;

   typedef struct {
      logic        wr_vld;
      logic [9:0]  wr_addr;
      logic [63:0] wr_data;
      logic [63:0] wr_mask;
      logic        rd_vld;
      logic [9:0]  rd_addr;
      logic        exp_wr_rdy;
      logic        exp_rd_rdy;
      logic        exp_cen;
      logic        exp_gwen;
      logic [63:0] exp_wen;
      logic [9:0]  exp_a;
      logic        chk_d;
      logic [63:0] exp_d;
   } vec_t;

   exp_t        sb[$];
   logic [63:0] ref_mem [1024];
   logic [63:0] last_rd;
   int          cyc_cnt = 0;
   int          checks  = 0;
   int          errors  = 0;
   vec_t        vt [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic ref_clear();
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
   endtask

   // Called once per cycle at the falling edge: retires reads, tracks accepts
   task automatic monitor();
      exp_t e;
      cyc_cnt++;
      if (bus.rd_data_vld === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got data 0x%0h expected no read", bus.rd_data);
         end else begin
            e = sb.pop_front();
            check("rd_data", bus.rd_data, e.data);
            check("rd_latency", 64'(cyc_cnt - e.cyc), 64'(LAT));
         end
         last_rd = bus.rd_data;
      end else if (!rst) begin
         check("rd_hold", bus.rd_data, last_rd);
      end
      if (rst) begin
         sb.delete();
         last_rd = '0;
      end else begin
         if (bus.wr_vld && bus.wr_rdy)
            ref_mem[bus.wr_addr] = (ref_mem[bus.wr_addr] & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
         if (bus.rd_vld && bus.rd_rdy)
            sb.push_back('{ref_mem[bus.rd_addr], cyc_cnt});
      end
   endtask

   task automatic obs();
      @(negedge clk);
      monitor();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.inv_req = 1'b0;
      bus.wr_vld  = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_mask = '0;
      bus.rd_vld  = 1'b0;
      bus.rd_addr = '0;
   endtask

   task automatic watch_walk(input string name);
      int  idx, busy, dones, bad;
      bit  seen, fin;
      idx = 0; busy = 0; dones = 0; bad = 0; seen = 1'b0;
      for (int t = 0; t < 1400; t++) begin
         obs();
         if (bus.inv_busy) begin
            busy++;
            seen = 1'b1;
         end
         if (bus.inv_done) dones++;
         if (!bus.sram_cen) begin
            if (bus.sram_gwen !== 1'b0 || bus.sram_wen !== '0 || bus.sram_d !== '0 ||
                bus.sram_a !== 10'(idx)) bad++;
            idx++;
         end
         fin = seen && !bus.inv_busy;
         adv();
         if (fin) break;
      end
      check({name, "_busy_cycles"}, 64'(busy), 64'd1025);
      check({name, "_done_pulses"}, 64'(dones), 64'd1);
      check({name, "_entries"}, 64'(idx), 64'd1024);
      check({name, "_bad_pins"}, 64'(bad), 64'd0);
   endtask

   task automatic check_pins(input int i);
      check($sformatf("cen[%0d]", i), 64'(bus.sram_cen), 64'(vt[i].exp_cen));
      if (!vt[i].exp_cen) begin
         check($sformatf("gwen[%0d]", i), 64'(bus.sram_gwen), 64'(vt[i].exp_gwen));
         check($sformatf("wen[%0d]", i), bus.sram_wen, vt[i].exp_wen);
         check($sformatf("a[%0d]", i), 64'(bus.sram_a), 64'(vt[i].exp_a));
         if (vt[i].chk_d) check($sformatf("d[%0d]", i), bus.sram_d, vt[i].exp_d);
      end
   endtask

   initial begin
      int  viol, dones;
      bit  second, pulsed, fin, hit;

      vt[0]  = '{1'b1, 10'h155, 64'hDEADBEEF_CAFEF00D, AO, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 10'h155, 1'b1, 64'hDEADBEEF_CAFEF00D};
      vt[1]  = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h155, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h155, 1'b0, 64'h0};
      vt[2]  = '{1'b1, 10'h005, AO, 64'h00000000_FFFF0000, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFF_0000FFFF, 10'h005, 1'b1, AO};
      vt[3]  = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h005, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h005, 1'b0, 64'h0};
      vt[4]  = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b0, 10'h0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h0, 10'h0, 1'b0, 64'h0};
      vt[5]  = '{1'b1, 10'h02A, 64'h01234567_89ABCDEF, AO, 1'b1, 10'h02A, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 10'h02A, 1'b1, 64'h01234567_89ABCDEF};
      vt[6]  = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h02A, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h02A, 1'b0, 64'h0};
      vt[7]  = '{1'b1, 10'h3FF, AO, 64'h0, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, AO, 10'h3FF, 1'b1, AO};
      vt[8]  = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h3FF, 1'b0, 64'h0};
      vt[9]  = '{1'b1, 10'h100, AO, 64'hFF, 1'b0, 10'h0, 1'b1, 1'b0, 1'b0, 1'b0, ~64'hFF, 10'h100, 1'b1, AO};
      vt[10] = '{1'b1, 10'h100, 64'h0, 64'hF0, 1'b1, 10'h101, 1'b1, 1'b0, 1'b0, 1'b0, ~64'hF0, 10'h100, 1'b1, 64'h0};
      vt[11] = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h100, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h100, 1'b0, 64'h0};
      vt[12] = '{1'b0, 10'h0, 64'h0, 64'h0, 1'b1, 10'h101, 1'b1, 1'b1, 1'b0, 1'b1, AO, 10'h101, 1'b0, 64'h0};

      last_rd = '0;
      ref_clear();
      idle_in();
      rst = 1'b1;
      adv();
      repeat (3) begin
         obs();
         adv();
      end

      obs();
      check("rst_inv_busy", 64'(bus.inv_busy), 64'd0);
      check("rst_inv_done", 64'(bus.inv_done), 64'd0);
      check("rst_rd_data_vld", 64'(bus.rd_data_vld), 64'd0);
      check("rst_rd_data", bus.rd_data, 64'd0);
      check("rst_sram_cen", 64'(bus.sram_cen), 64'd1);
      check("rst_sram_gwen", 64'(bus.sram_gwen), 64'd1);
      check("rst_sram_wen", bus.sram_wen, AO);
      check("rst_sram_a", 64'(bus.sram_a), 64'd0);
      check("rst_sram_d", bus.sram_d, 64'd0);
      adv();
      rst = 1'b0;

      watch_walk("walk0");
      ref_clear();

      for (int i = 0; i < 13; i++) begin
         bus.wr_vld  = vt[i].wr_vld;
         bus.wr_addr = vt[i].wr_addr;
         bus.wr_data = vt[i].wr_data;
         bus.wr_mask = vt[i].wr_mask;
         bus.rd_vld  = vt[i].rd_vld;
         bus.rd_addr = vt[i].rd_addr;
         obs();
         check($sformatf("wr_rdy[%0d]", i), 64'(bus.wr_rdy), 64'(vt[i].exp_wr_rdy));
         check($sformatf("rd_rdy[%0d]", i), 64'(bus.rd_rdy), 64'(vt[i].exp_rd_rdy));
         if (i > 0) check_pins(i - 1);
         adv();
      end
      idle_in();
      obs();
      check_pins(12);
      adv();
      repeat (5) begin
         obs();
         adv();
      end
      check("sb_drain_table", 64'(sb.size()), 64'd0);

      // Invalidate wins over simultaneous write/read; read waits out the walk
      bus.inv_req = 1'b1;
      bus.wr_vld  = 1'b1;
      bus.wr_addr = 10'h155;
      bus.wr_data = AO;
      bus.wr_mask = AO;
      bus.rd_vld  = 1'b1;
      bus.rd_addr = 10'h155;
      obs();
      check("inv_wr_rdy", 64'(bus.wr_rdy), 64'd0);
      check("inv_rd_rdy", 64'(bus.rd_rdy), 64'd0);
      adv();
      bus.inv_req = 1'b0;
      bus.wr_vld  = 1'b0;
      viol = 0; dones = 0; second = 1'b0; pulsed = 1'b0; fin = 1'b0;
      for (int t = 0; t < 1400; t++) begin
         obs();
         if (bus.rd_rdy) viol++;
         if (bus.inv_done) dones++;
         if (!bus.sram_cen && bus.sram_a == 10'd500) second = 1'b1;
         fin = bus.inv_done;
         adv();
         bus.inv_req = second && !pulsed;
         if (second) pulsed = 1'b1;
         if (fin) break;
      end
      bus.inv_req = 1'b0;
      ref_clear();
      obs();
      check("rd_rdy_after_walk", 64'(bus.rd_rdy), 64'd1);
      adv();
      bus.rd_vld = 1'b0;
      repeat (6) begin
         obs();
         if (bus.inv_done) dones++;
         adv();
      end
      check("walk_rd_rdy_violations", 64'(viol), 64'd0);
      check("walk_inv_done_count", 64'(dones), 64'd1);
      check("sb_drain_walk", 64'(sb.size()), 64'd0);

      // Reset in the middle of a walk
      bus.inv_req = 1'b1;
      obs();
      adv();
      bus.inv_req = 1'b0;
      hit = 1'b0;
      for (int t = 0; t < 1400; t++) begin
         obs();
         if (!bus.sram_cen && bus.sram_a == 10'd300) hit = 1'b1;
         adv();
         if (hit) break;
      end
      check("walk_reached_300", 64'(hit), 64'd1);
      rst = 1'b1;
      obs();
      adv();
      obs();
      check("midrst_inv_busy", 64'(bus.inv_busy), 64'd0);
      check("midrst_sram_cen", 64'(bus.sram_cen), 64'd1);
      check("midrst_rd_data_vld", 64'(bus.rd_data_vld), 64'd0);
      adv();
      rst = 1'b0;
      watch_walk("walk_restart");
      ref_clear();

      bus.rd_vld  = 1'b1;
      bus.rd_addr = 10'h02A;
      obs();
      adv();
      bus.rd_vld = 1'b0;
      repeat (5) begin
         obs();
         adv();
      end
      check("sb_drain_final", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
